// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm: multicycle RV32I sequencer driving datapath selects/enables and the memory handshake.
// Optional CTRL_PERF_CNT_EN adds cycle_cnt/instret_cnt performance counters.
module multicycle_ctrl_fsm #(
   parameter int WAIT_MAX = 255
`ifdef CTRL_PERF_CNT_EN
   ,parameter int CNT_W = 32
`endif
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] op,
   input  logic       br_taken,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_write,
   output logic       adr_src,
   output logic       ir_write,
   output logic       pc_write,
   output logic       reg_write,
   output logic [1:0] result_src,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic       halted,
   output logic       illegal_op,
   output logic       bus_timeout
`ifdef CTRL_PERF_CNT_EN
   ,output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] instret_cnt
`endif
);
   localparam int WW = $clog2(WAIT_MAX + 1);
   typedef enum logic [3:0] {
      FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXR, EXI,
      ALUWB, BRANCH, JAL, JALR, JALR2, LUI, AUIPC, HALT
   } state_t;
   state_t state;
   logic [WW-1:0] wait_cnt;
   logic timeout;
   assign halted = state == HALT;
   // halting happens on the wait cycle that would bring the count up to WAIT_MAX
   assign timeout = mem_req && !mem_ready && wait_cnt == WW'(WAIT_MAX - 1);
   always_comb begin
      mem_req = 1'b0;
      mem_write = 1'b0;
      adr_src = 1'b0;
      ir_write = 1'b0;
      pc_write = 1'b0;
      reg_write = 1'b0;
      result_src = 2'b00;
      alu_src_a = 2'b00;
      alu_src_b = 2'b00;
      alu_op = 2'b00;
      if (!reset)
         case (state)
            FETCH: begin
               mem_req = 1'b1;
               if (mem_ready) begin
                  ir_write = 1'b1;
                  pc_write = 1'b1;
                  alu_src_b = 2'b10;
                  result_src = 2'b10;
               end
            end
            DECODE: begin
               alu_src_a = 2'b01;
               alu_src_b = 2'b01;
            end
            MEMADR, JALR: begin
               alu_src_a = 2'b10;
               alu_src_b = 2'b01;
            end
            MEMREAD: begin
               mem_req = 1'b1;
               adr_src = 1'b1;
            end
            MEMWB: begin
               result_src = 2'b01;
               reg_write = 1'b1;
            end
            MEMWRITE: begin
               mem_req = 1'b1;
               mem_write = 1'b1;
               adr_src = 1'b1;
            end
            EXR: begin
               alu_src_a = 2'b10;
               alu_op = 2'b10;
            end
            EXI: begin
               alu_src_a = 2'b10;
               alu_src_b = 2'b01;
               alu_op = 2'b10;
            end
            ALUWB: reg_write = 1'b1;
            BRANCH: begin
               alu_src_a = 2'b10;
               alu_op = 2'b01;
               pc_write = br_taken;
            end
            JAL, JALR2: begin
               alu_src_a = 2'b01;
               alu_src_b = 2'b10;
               pc_write = 1'b1;
            end
            LUI: begin
               alu_src_a = 2'b11;
               alu_src_b = 2'b01;
            end
            AUIPC: begin
               alu_src_a = 2'b01;
               alu_src_b = 2'b01;
            end
            default: ;
         endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= FETCH;
         wait_cnt <= '0;
         illegal_op <= 1'b0;
         bus_timeout <= 1'b0;
      end else begin
         wait_cnt <= (mem_req && !mem_ready && !timeout) ? wait_cnt + 1'b1 : '0;
         if (timeout) begin
            state <= HALT;
            bus_timeout <= 1'b1;
         end else
            case (state)
               FETCH: if (mem_ready) state <= DECODE;
               DECODE:
                  case (op)
                     7'b0000011, 7'b0100011: state <= MEMADR;
                     7'b0110011: state <= EXR;
                     7'b0010011: state <= EXI;
                     7'b1100011: state <= BRANCH;
                     7'b1101111: state <= JAL;
                     7'b1100111: state <= JALR;
                     7'b0110111: state <= LUI;
                     7'b0010111: state <= AUIPC;
                     default: begin
                        state <= HALT;
                        illegal_op <= 1'b1;
                     end
                  endcase
               MEMADR: state <= op[5] ? MEMWRITE : MEMREAD;
               MEMREAD: if (mem_ready) state <= MEMWB;
               MEMWRITE: if (mem_ready) state <= FETCH;
               MEMWB, ALUWB, BRANCH: state <= FETCH;
               EXR, EXI, JAL, JALR2, LUI, AUIPC: state <= ALUWB;
               JALR: state <= JALR2;
               default: state <= HALT;
            endcase
      end
   end
`ifdef CTRL_PERF_CNT_EN
   logic retire;
   assign retire = state == MEMWB || state == ALUWB || state == BRANCH || (state == MEMWRITE && mem_ready);
   always_ff @(posedge clk) begin
      if (reset) begin
         cycle_cnt <= '0;
         instret_cnt <= '0;
      end else begin
         cycle_cnt <= cycle_cnt + 1'b1;
         instret_cnt <= instret_cnt + CNT_W'(retire);
      end
   end
`endif
endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// tb_multicycle_ctrl_fsm: directed checks of the multicycle control sequencer with hand-computed expectations.
module tb_multicycle_ctrl_fsm;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [6:0] op = 7'b0010011;
   logic br_taken = 1'b0;
   logic mem_ready = 1'b1;
   logic mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
   logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
   logic halted, illegal_op, bus_timeout;
   int n_chk = 0;
   int n_fail = 0;
`ifdef CTRL_PERF_CNT_EN
   logic [31:0] cycle_cnt, instret_cnt;
`endif
   multicycle_ctrl_fsm #(.WAIT_MAX(4)) dut (
      .clk(clk), .reset(reset), .op(op), .br_taken(br_taken), .mem_ready(mem_ready),
      .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src), .ir_write(ir_write),
      .pc_write(pc_write), .reg_write(reg_write), .result_src(result_src),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .halted(halted), .illegal_op(illegal_op), .bus_timeout(bus_timeout)
`ifdef CTRL_PERF_CNT_EN
      , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic settle();
      #1;
   endtask
   initial begin
      tick(3);
      check("reset_en", 32'({mem_req, mem_write, ir_write, pc_write, reg_write}), 0);
      reset = 1'b0;
      settle();
      check("fetch_req", 32'({mem_req, adr_src}), 32'b10);
      check("fetch_en", 32'({ir_write, pc_write, reg_write}), 32'b110);
      check("fetch_sel", 32'({alu_src_a, alu_src_b, alu_op, result_src}), 32'b00_10_00_10);
      tick();
      check("decode_sel", 32'({alu_src_a, alu_src_b, alu_op, reg_write}), 32'b01_01_00_0);
      tick();
      check("exi_sel", 32'({alu_src_a, alu_src_b, alu_op, reg_write}), 32'b10_01_10_0);
      tick();
      check("aluwb", 32'({reg_write, result_src}), 32'b1_00);
      op = 7'b0000011;
      tick();
      check("fetch_after_alu", 32'({mem_req, reg_write}), 32'b10);
      tick(2);
      check("memadr_sel", 32'({alu_src_a, alu_src_b, alu_op}), 32'b10_01_00);
      tick();
      mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (i == 2) mem_ready = 1'b1;
         settle();
         check("memread_req", 32'({mem_req, adr_src, mem_write, reg_write}), 32'b1100);
         tick();
      end
      check("memwb", 32'({reg_write, result_src}), 32'b1_01);
      op = 7'b1100011;
      tick(3);
      check("branch_nt", 32'({pc_write, alu_op, alu_src_a, alu_src_b}), 32'b0_01_10_00);
      br_taken = 1'b1;
      tick(3);
      check("branch_t", 32'({pc_write, alu_op, alu_src_a, alu_src_b}), 32'b1_01_10_00);
      br_taken = 1'b0;
      op = 7'b0100011;
      tick(4);
      check("memwrite", 32'({mem_req, mem_write, adr_src, reg_write}), 32'b1110);
      op = 7'b1101111;
      tick();
      check("store_done", 32'({mem_write, ir_write}), 32'b01);
      tick(2);
      check("jal_sel", 32'({pc_write, alu_src_a, alu_src_b, alu_op}), 32'b1_01_10_00);
      tick();
      check("jal_wb", 32'({reg_write, result_src, pc_write}), 32'b1_00_0);
      op = 7'b1111111;
      tick(2);
      check("illegal_decode", 32'({halted, alu_src_a}), 32'b0_01);
      tick();
      for (int i = 0; i < 20; i++) begin
         check("halt_flags", 32'({halted, illegal_op, bus_timeout}), 32'b110);
         check("halt_en", 32'({mem_req, mem_write, ir_write, pc_write, reg_write}), 0);
         tick();
      end
      reset = 1'b1;
      op = 7'b0010011;
      tick();
      reset = 1'b0;
      settle();
      check("resume_flags", 32'({halted, illegal_op, bus_timeout}), 0);
      check("resume_fetch", 32'({mem_req, adr_src, ir_write}), 32'b101);
      mem_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         settle();
         check("wait_fetch", 32'({mem_req, ir_write, halted}), 32'b100);
         tick();
      end
      check("timeout_flags", 32'({halted, illegal_op, bus_timeout}), 32'b101);
      check("timeout_en", 32'({mem_req, ir_write, pc_write}), 0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      settle();
      check("timeout_cleared", 32'({halted, bus_timeout}), 0);
      tick(3);
      mem_ready = 1'b1;
      settle();
      check("ready_on_4th", 32'({mem_req, ir_write, halted}), 32'b110);
      tick();
      check("no_timeout", 32'({halted, bus_timeout, alu_src_a, alu_src_b}), 32'b0_0_01_01);
`ifdef CTRL_PERF_CNT_EN
      reset = 1'b1;
      tick();
      check("perf_reset", cycle_cnt | instret_cnt, 0);
      reset = 1'b0;
      tick(40);
      check("instret_10", instret_cnt, 10);
      check("cycle_40", cycle_cnt, 40);
      op = 7'b0100011;
      tick(3);
      mem_ready = 1'b0;
      tick(2);
      check("in_memwrite", 32'({mem_req, mem_write}), 32'b11);
      reset = 1'b1;
      tick();
      check("perf_mid_reset", cycle_cnt | instret_cnt, 0);
      check("reset_no_req", 32'({mem_req, mem_write}), 0);
      reset = 1'b0;
      mem_ready = 1'b1;
      settle();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
